// File: rtl/motor_proto_pkg.sv
// Motor-controller UART protocol constants, host FSM state type and the
// command frame encoder shared by the host initiator and its bench.
package motor_proto_pkg;

  localparam logic [3:0]  POLL_ADDR  = 4'hF;
  localparam int unsigned CMD_BYTES  = 5;
  localparam int unsigned STAT_BYTES = 4;
  localparam logic [7:0]  POLL_BYTE  = {4'h0, POLL_ADDR};

  localparam logic [1:0] TAG_PEND_LO = 2'd0;
  localparam logic [1:0] TAG_PEND_HI = 2'd1;
  localparam logic [1:0] TAG_LIM_LO  = 2'd2;
  localparam logic [1:0] TAG_LIM_HI  = 2'd3;

  typedef logic [CMD_BYTES-1:0][7:0] cmdFrame_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD_SEND,
    CMD_GAP,
    POLL_SEND,
    POLL_RX,
    STAT_OUT
  } hostState_t;

  // Byte 0 goes out first; byte 4 is a fixed zero trailer.
  function automatic cmdFrame_t encodeCmd(input logic [3:0]  motor,
                                          input logic [15:0] divider,
                                          input logic [10:0] steps,
                                          input logic        dir);
    cmdFrame_t f;
    f[0] = {divider[3:0], motor};
    f[1] = divider[11:4];
    f[2] = {steps[3:0], divider[15:12]};
    f[3] = {dir, steps[10:4]};
    f[4] = 8'h00;
    return f;
  endfunction

endpackage

// File: rtl/motor_status_parser.sv
// Status reply parser: detects rx strobes, checks byte tags, collects the
// pending/limit fields in shadow registers and flags completion or error.
module motor_status_parser
  import motor_proto_pkg::*;
#(
  parameter logic [19:0] RESP_TIMEOUT = 20'hfffff
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       start,
  input  logic       rx_data_ready,
  input  logic [7:0] rx_data,
  output logic       done,
  output logic       err,
  output logic [9:0] pendShadow,
  output logic [9:0] limitShadow
);

  logic        rxPrev;
  logic        armed;
  logic        rxRise;
  logic        tagOk;
  logic [1:0]  idx;
  logic [19:0] timer;

  assign rxRise = rx_data_ready & ~rxPrev;
  assign tagOk  = (rx_data[7:6] == idx) && !rx_data[5];
  assign done   = armed && rxRise && tagOk && (idx == 2'(STAT_BYTES - 1));
  // A byte arriving on the last timer cycle still counts as in time.
  assign err    = armed && ((rxRise && !tagOk) || (!rxRise && timer == '0));

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      rxPrev      <= 1'b0;
      armed       <= 1'b0;
      idx         <= '0;
      timer       <= '0;
      pendShadow  <= '0;
      limitShadow <= '0;
    end else begin
      rxPrev <= rx_data_ready;
      if (start) begin
        armed <= 1'b1;
        idx   <= '0;
        timer <= RESP_TIMEOUT;
      end else if (armed) begin
        if (timer != '0) timer <= timer - 1'b1;
        if (rxRise && tagOk) begin
          case (idx)
            TAG_PEND_LO: pendShadow[4:0]  <= rx_data[4:0];
            TAG_PEND_HI: pendShadow[9:5]  <= rx_data[4:0];
            TAG_LIM_LO:  limitShadow[4:0] <= rx_data[4:0];
            TAG_LIM_HI:  limitShadow[9:5] <= rx_data[4:0];
          endcase
          idx <= idx + 1'b1;
        end
        if (done || err) armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/motor_cmd_host.sv
// Host-side initiator for the motor-controller UART protocol: sends 5-byte
// command frames and 1-byte status polls, and publishes parsed status.
module motor_cmd_host
  import motor_proto_pkg::*;
#(
  parameter logic [17:0] BYTE_GAP     = 18'h0fff,
  parameter logic [19:0] RESP_TIMEOUT = 20'hfffff,
  parameter int unsigned NUM_MOTORS   = 10
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_motor,
  input  logic [15:0] cmd_divider,
  input  logic [10:0] cmd_steps,
  input  logic        cmd_dir,
  input  logic        poll_req,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_data_ready,
  input  logic [7:0]  rx_data,
  output logic        status_valid,
  output logic [9:0]  pending,
  output logic [9:0]  limit,
  output logic        status_err,
  output logic        busy
);

  hostState_t  state, stateNext;
  cmdFrame_t   frame;
  logic [2:0]  idx;
  logic [17:0] gapCnt;
  logic        pollLatched;
  logic        cmdXfer, cmdBad, sendNow, parseStart, parseDone, parseErr;
  logic [9:0]  pendShadow, limitShadow;

  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE) && !reset;
  assign cmdXfer   = cmd_valid && cmd_ready;
  assign cmdBad    = 32'(cmd_motor) >= NUM_MOTORS;

  motor_status_parser #(.RESP_TIMEOUT(RESP_TIMEOUT)) uParser (
    .CLOCK_25      (CLOCK_25),
    .reset         (reset),
    .start         (parseStart),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .done          (parseDone),
    .err           (parseErr),
    .pendShadow    (pendShadow),
    .limitShadow   (limitShadow)
  );

  always_comb begin
    stateNext  = state;
    sendNow    = 1'b0;
    parseStart = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmdXfer)          stateNext = cmdBad ? IDLE : CMD_SEND;
        else if (pollLatched) stateNext = POLL_SEND;
      end
      CMD_SEND: begin
        if (!tx_busy) begin
          sendNow   = 1'b1;
          stateNext = CMD_GAP;
        end
      end
      CMD_GAP: begin
        if (gapCnt == '0 && !tx_busy)
          stateNext = (idx == 3'(CMD_BYTES - 1)) ? IDLE : CMD_SEND;
      end
      POLL_SEND: begin
        if (!tx_busy) begin
          sendNow    = 1'b1;
          parseStart = 1'b1;
          stateNext  = POLL_RX;
        end
      end
      POLL_RX: begin
        if (parseDone)     stateNext = STAT_OUT;
        else if (parseErr) stateNext = IDLE;
      end
      STAT_OUT: stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state        <= IDLE;
      frame        <= '0;
      idx          <= '0;
      gapCnt       <= '0;
      pollLatched  <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      status_valid <= 1'b0;
      status_err   <= 1'b0;
      pending      <= '0;
      limit        <= '0;
    end else begin
      state        <= stateNext;
      tx_start     <= sendNow;
      status_valid <= (state == STAT_OUT);
      status_err   <= (state == IDLE && cmdXfer && cmdBad) ||
                      (state == POLL_RX && parseErr);

      // Requests arriving while a poll is already underway merge into it.
      if (state == IDLE && !cmdXfer && pollLatched)
        pollLatched <= 1'b0;
      else if (poll_req && !(state inside {POLL_SEND, POLL_RX, STAT_OUT}))
        pollLatched <= 1'b1;

      if (state == IDLE && cmdXfer) begin
        frame <= encodeCmd(cmd_motor, cmd_divider, cmd_steps, cmd_dir);
        idx   <= '0;
      end

      if (sendNow) begin
        tx_data <= (state == POLL_SEND) ? POLL_BYTE : frame[idx];
        gapCnt  <= BYTE_GAP;
      end else if (state == CMD_GAP && gapCnt != '0) begin
        gapCnt <= gapCnt - 1'b1;
      end

      if (state == CMD_GAP && stateNext == CMD_SEND) idx <= idx + 1'b1;

      if (state == STAT_OUT) begin
        pending <= pendShadow;
        limit   <= limitShadow;
      end
    end
  end

endmodule

// File: tb/tb_motor_cmd_host.sv
// Self-checking bench for motor_cmd_host: table vectors, corner sequences and
// randomized commands/polls against a frame-level reference model.
module tb_motor_cmd_host;
  import motor_proto_pkg::*;

  localparam logic [17:0] GAP   = 18'd30;
  localparam logic [19:0] TMO   = 20'd600;
  localparam int          TXLEN = 12;

  logic        CLOCK_25 = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_dir = 1'b0, poll_req = 1'b0;
  logic        tx_busy = 1'b0, rx_data_ready = 1'b0;
  logic [3:0]  cmd_motor = '0;
  logic [15:0] cmd_divider = '0;
  logic [10:0] cmd_steps = '0;
  logic [7:0]  rx_data = '0;
  logic        cmd_ready, tx_start, status_valid, status_err, busy;
  logic [7:0]  tx_data;
  logic [9:0]  pending, limit;

  int checks = 0, errors = 0, cycle = 0;
  logic [7:0] txQ[$];
  int txCyc[$];
  int busyCnt = 0, validCnt = 0, errCnt = 0, lastValidCyc = 0, lastErrCyc = 0;
  logic [9:0] modelPend = '0, modelLim = '0;

  motor_cmd_host #(.BYTE_GAP(GAP), .RESP_TIMEOUT(TMO), .NUM_MOTORS(10)) dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_motor(cmd_motor), .cmd_divider(cmd_divider), .cmd_steps(cmd_steps),
    .cmd_dir(cmd_dir), .poll_req(poll_req), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .status_valid(status_valid), .pending(pending), .limit(limit),
    .status_err(status_err), .busy(busy)
  );

  always #20 CLOCK_25 = ~CLOCK_25;
  always @(posedge CLOCK_25) cycle++;

  // Transmitter model and output monitors.
  always @(negedge CLOCK_25) begin
    if (tx_start) begin
      txQ.push_back(tx_data);
      txCyc.push_back(cycle);
      busyCnt = TXLEN;
    end else if (busyCnt > 0) begin
      busyCnt--;
    end
    tx_busy = (busyCnt != 0);
    if (status_valid) begin validCnt++; lastValidCyc = cycle; end
    if (status_err)   begin errCnt++;   lastErrCyc   = cycle; end
  end

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge CLOCK_25); #1; end
  endtask

  // Frame model: the command word laid out little-endian over 40 bits.
  function automatic logic [7:0] refByte(input logic [3:0] m, input logic [15:0] d,
                                         input logic [10:0] s, input logic dir, input int i);
    logic [39:0] w;
    w = {8'h00, dir, s, d, m};
    return w[8*i +: 8];
  endfunction

  task automatic waitIdle(input string nm);
    int k = 0;
    while (busy && k < 3000) begin tick(); k++; end
    if (busy) check({nm, "_idle_timeout"}, 32'(busy), 0);
  endtask

  task automatic issueCmd(input logic [3:0] m, input logic [15:0] d, input logic [10:0] s,
                          input logic dir, input logic withPoll);
    waitIdle("issue");
    cmd_motor = m; cmd_divider = d; cmd_steps = s; cmd_dir = dir;
    cmd_valid = 1'b1; poll_req = withPoll;
    tick();
    cmd_valid = 1'b0; poll_req = 1'b0;
  endtask

  task automatic runCmd(input string nm, input logic [3:0] m, input logic [15:0] d,
                        input logic [10:0] s, input logic dir, input logic [4:0][7:0] exp);
    int k = 0;
    int sizeAtReady = -1;
    txQ.delete(); txCyc.delete();
    issueCmd(m, d, s, dir, 1'b0);
    while (!cmd_ready && k < 3000) begin tick(); k++; end
    sizeAtReady = txQ.size();
    check({nm, "_ready_after_last"}, 32'(sizeAtReady), 5);
    for (int i = 0; i < 5; i++)
      if (i < txQ.size()) check({nm, "_byte"}, 32'(txQ[i]), 32'(exp[i]));
    for (int i = 1; i < txCyc.size(); i++)
      check({nm, "_gap_ok"}, 32'(txCyc[i] - txCyc[i-1] >= int'(GAP)), 1);
  endtask

  task automatic runPoll(input string nm, input logic [3:0][7:0] rx, input int n,
                         input logic expValid, input logic [9:0] expPend,
                         input logic [9:0] expLim, input logic checkLat);
    int vc0, ec0, k, rxCyc, lat;
    waitIdle(nm);
    txQ.delete(); txCyc.delete();
    vc0 = validCnt; ec0 = errCnt; rxCyc = cycle;
    poll_req = 1'b1; tick(); poll_req = 1'b0;
    k = 0;
    while (txQ.size() == 0 && k < 500) begin tick(); k++; end
    for (int i = 0; i < n; i++) begin
      rx_data = rx[i]; rx_data_ready = 1'b1; rxCyc = cycle;
      tick(); rx_data_ready = 1'b0; tick(3);
    end
    k = 0;
    while (validCnt == vc0 && errCnt == ec0 && k < int'(TMO) + 100) begin tick(); k++; end
    tick(3);
    check({nm, "_txcount"}, 32'(txQ.size()), 1);
    if (txQ.size() > 0) check({nm, "_pollbyte"}, 32'(txQ[0]), 32'h0F);
    check({nm, "_valid"}, 32'(validCnt - vc0), 32'(expValid));
    check({nm, "_err"}, 32'(errCnt - ec0), 32'(!expValid));
    check({nm, "_pending"}, 32'(pending), 32'(expPend));
    check({nm, "_limit"}, 32'(limit), 32'(expLim));
    check({nm, "_idle"}, 32'(busy), 0);
    if (checkLat && expValid) begin
      lat = lastValidCyc - rxCyc;
      check({nm, "_valid_latency"}, 32'(lat >= 1 && lat <= 3), 1);
    end
    if (checkLat && !expValid && txCyc.size() > 0) begin
      lat = lastErrCyc - txCyc[0];
      check({nm, "_timeout_latency"}, 32'(lat >= int'(TMO) - 2 && lat <= int'(TMO) + 2), 1);
    end
  endtask

  function automatic logic [3:0][7:0] mk4(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  typedef struct {
    logic [3:0]       m;
    logic [15:0]      d;
    logic [10:0]      s;
    logic             dir;
    logic [4:0][7:0]  exp;
  } cmdVec_t;

  typedef struct {
    logic [3:0][7:0] rx;
    int              n;
    logic            expValid;
    logic [9:0]      expPend;
    logic [9:0]      expLim;
  } pollVec_t;

  cmdVec_t  cv[3];
  pollVec_t pv[4];

  initial begin
    logic [3:0]      rm;
    logic [15:0]     rd;
    logic [10:0]     rs;
    logic            rdir;
    logic [4:0][7:0] rexp;
    logic [3:0][7:0] rrx;
    logic [3:0]      badMotors;
    int              badAt, ec0, k;
    cmdFrame_t       f;

    cv[0] = '{4'd3, 16'h1234, 11'h2A5, 1'b1, {8'h00, 8'hAA, 8'h51, 8'h23, 8'h43}};
    cv[1] = '{4'd9, 16'hFFFF, 11'h7FF, 1'b0, {8'h00, 8'h7F, 8'hFF, 8'hFF, 8'hF9}};
    cv[2] = '{4'd0, 16'h0000, 11'h000, 1'b1, {8'h00, 8'h80, 8'h00, 8'h00, 8'h00}};
    pv[0] = '{mk4(8'h05, 8'h41, 8'h9F, 8'hC0), 4, 1'b1, 10'h025, 10'h01F};
    pv[1] = '{mk4(8'h05, 8'h81, 8'h00, 8'h00), 2, 1'b0, 10'h025, 10'h01F};
    pv[2] = '{mk4(8'h25, 8'h00, 8'h00, 8'h00), 1, 1'b0, 10'h025, 10'h01F};
    pv[3] = '{mk4(8'h1F, 8'h5F, 8'h80, 8'hDF), 4, 1'b1, 10'h3FF, 10'h3E0};

    tick(3);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_status", 32'({status_valid, status_err}), 0);
    check("rst_fields", 32'({pending, limit}), 0);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 3; i++) runCmd("cmd_table", cv[i].m, cv[i].d, cv[i].s, cv[i].dir, cv[i].exp);
    for (int i = 0; i < 4; i++)
      runPoll("poll_table", pv[i].rx, pv[i].n, pv[i].expValid, pv[i].expPend, pv[i].expLim, i == 0);
    modelPend = 10'h3FF; modelLim = 10'h3E0;

    runPoll("poll_timeout", '0, 0, 1'b0, modelPend, modelLim, 1'b1);

    // Invalid motor indices: accepted, never transmitted, one error pulse each.
    badMotors = 4'hA;
    for (int i = 0; i < 2; i++) begin
      txQ.delete(); ec0 = errCnt;
      issueCmd(badMotors, 16'h1111, 11'h011, 1'b0, 1'b0);
      tick(int'(GAP) + 20);
      check("badmotor_no_tx", 32'(txQ.size()), 0);
      check("badmotor_err", 32'(errCnt - ec0), 1);
      badMotors = 4'hF;
    end

    // Command and poll presented together: full frame first, then the poll.
    txQ.delete(); txCyc.delete();
    issueCmd(4'd7, 16'hBEEF, 11'h155, 1'b0, 1'b1);
    k = 0;
    while (txQ.size() < 6 && k < 2000) begin tick(); k++; end
    check("both_txcount", 32'(txQ.size()), 6);
    for (int i = 0; i < 6 && i < txQ.size(); i++)
      check("both_byte", 32'(txQ[i]), 32'(i < 5 ? refByte(4'd7, 16'hBEEF, 11'h155, 1'b0, i) : 8'h0F));
    rrx = mk4(8'h0A, 8'h55, 8'h83, 8'hD1);
    for (int i = 0; i < 4; i++) begin
      rx_data = rrx[i]; rx_data_ready = 1'b1; tick(); rx_data_ready = 1'b0; tick(2);
    end
    tick(4);
    modelPend = {rrx[1][4:0], rrx[0][4:0]};
    modelLim  = {rrx[3][4:0], rrx[2][4:0]};
    check("both_pending", 32'(pending), 32'(modelPend));
    check("both_limit", 32'(limit), 32'(modelLim));

    f = encodeCmd(4'd5, 16'hA5C3, 11'h3E1, 1'b1);
    for (int i = 0; i < 5; i++) check("encode_fn", 32'(f[i]), 32'(refByte(4'd5, 16'hA5C3, 11'h3E1, 1'b1, i)));

    // Randomized commands against the frame model.
    for (int t = 0; t < 8; t++) begin
      rm = 4'($urandom_range(0, 9)); rd = 16'($urandom); rs = 11'($urandom); rdir = 1'($urandom);
      for (int i = 0; i < 5; i++) rexp[i] = refByte(rm, rd, rs, rdir, i);
      runCmd("cmd_rand", rm, rd, rs, rdir, rexp);
    end

    // Randomized polls: optionally corrupt one byte's tag or reserved bit.
    for (int t = 0; t < 8; t++) begin
      badAt = $urandom_range(0, 6);
      for (int i = 0; i < 4; i++) begin
        rrx[i] = {2'(i), 1'b0, 5'($urandom)};
        if (i == badAt) begin
          if ($urandom_range(0, 1) == 1) rrx[i][5] = 1'b1;
          else rrx[i][7:6] = 2'(i + 1 + $urandom_range(0, 2));
        end
      end
      if (badAt >= 4) begin
        modelPend = {rrx[1][4:0], rrx[0][4:0]};
        modelLim  = {rrx[3][4:0], rrx[2][4:0]};
      end
      runPoll("poll_rand", rrx, badAt >= 4 ? 4 : badAt + 1, badAt >= 4, modelPend, modelLim, 1'b0);
    end

    // Reset while byte 2 of a frame is going out.
    txQ.delete(); txCyc.delete();
    issueCmd(cv[0].m, cv[0].d, cv[0].s, cv[0].dir, 1'b0);
    k = 0;
    while (txQ.size() < 3 && k < 2000) begin tick(); k++; end
    check("rstmid_reached_b2", 32'(txQ.size()), 3);
    reset = 1'b1;
    tick(3);
    check("rstmid_ready_low", 32'(cmd_ready), 0);
    check("rstmid_fields_cleared", 32'({pending, limit}), 0);
    reset = 1'b0;
    #1;
    check("rstmid_ready_after", 32'(cmd_ready), 1);
    tick(int'(GAP) + 40);
    check("rstmid_no_more_tx", 32'(txQ.size()), 3);
    check("rstmid_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
